zjh_cnt_ctrl: RTL
=================

# zjh_cnt_ctrl

Run controller for a two-stage cascaded 4-bit counter (units/tens), each stage modelled on the 74HC161-style synchronous counter used in the datapath. Accepts a programmable terminal count per stage through a valid/ready handshake and sequences start, stop, free-run and one-shot operation. Emits a one-cycle chain carry and a done flag to downstream display and control logic.

## Interface
- No parameters; stage width is fixed at 4 bits.
- `Clk`  in  1  system clock, rising edge.
- `MR`  in  1  asynchronous reset, active-high.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted.
- `cfg_term_lo`  in  4  units-stage terminal value, 0..15.
- `cfg_term_hi`  in  4  tens-stage terminal value, 0..15.
- `cfg_oneshot`  in  1  1 = one-shot, 0 = free-run.
- `start`  in  1  start request, level sampled each cycle.
- `stop`  in  1  stop request, level sampled each cycle.
- `Q_lo`  out  4  units count.
- `Q_hi`  out  4  tens count.
- `C`  out  1  chain terminal carry.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, RUN, HOLD (only with the configuration macro), DONE.
- Reset values: state IDLE, Q_lo=0, Q_hi=0, term_lo=13, term_hi=0, oneshot=0. Outputs: C=0, busy=0, done=0, cfg_ready=1.
- Config transfer:
  - Occurs when `cfg_valid & cfg_ready`.
  - `cfg_ready` = 1 in IDLE and DONE only.
  - Captured values take effect on the next edge.
- IDLE:
  - `start` → RUN with Q_lo=Q_hi=0.
  - If a config transfer and `start` occur in the same cycle, the new config applies.
- RUN, each edge:
  - Q_lo increments. When Q_lo==term_lo, Q_lo wraps to 0 and the carry enables Q_hi.
  - Q_hi increments when carried. When Q_hi==term_hi, Q_hi wraps to 0.
  - Terminal = (Q_lo==term_lo)&(Q_hi==term_hi).
  - Free-run: wrap both stages to 0, stay in RUN.
  - One-shot: on terminal, hold the counts at terminal and go to DONE.
- Period = (term_lo+1)×(term_hi+1) cycles.
- A terminal value of 0 means the stage is always terminal (modulus 1).
- `C` = terminal & state==RUN, combinational from the registered counts.
- `stop` in RUN → IDLE with counts cleared. With the macro, → HOLD instead.
- `start` and `stop` in the same cycle: `stop` wins.
- DONE:
  - `start` → RUN from 0/0.
  - `stop` → IDLE with counts cleared.
- `MR` asserted at any time forces all reset values immediately, independent of `Clk`. The count in progress is lost.

## Timing
- `start` sampled at edge N: `busy`=1 after N. First increment (Q_lo=1) after edge N+1.
- `C` is high during exactly one cycle per period, in the cycle when the counts show terminal.
- One-shot: `done` rises at the edge following the cycle in which `C` was high.
- `cfg_ready` changes only on state change. There is no combinational path from `cfg_valid`.
- Release of `MR` is assumed synchronous to `Clk` at system level. No internal synchronizer.

## Configuration
- Macro: `ZJH_CNT_CTRL_PAUSE_EN`.
- Defined:
  - `stop` in RUN → HOLD with Q_lo/Q_hi retained. `busy`=0, `C`=0 in HOLD.
  - `start` in HOLD resumes RUN from the retained counts.
  - `stop` in HOLD → IDLE with counts cleared.
  - `cfg_ready`=0 in HOLD.
- Undefined: HOLD does not exist, and `stop` in RUN always clears to IDLE.

## Structure
- Package `zjh_cnt_pkg`:
  - state enumeration;
  - reset terminal constants TERM_LO_RST=13, TERM_HI_RST=0.
- Sub-module `zjh_cnt4_stage`:
  - one instance per stage;
  - 4-bit counter with async clear on `MR`, synchronous clear, count enable;
  - terminal input, terminal-compare output, carry output.
- The controller FSM, config registers and `C` generation live in the top module.

## Test plan
- Reset defaults, `start`, 30 cycles → Q_lo cycles 0..13, Q_hi stays 0, `C` high every 14th cycle, `done` never rises.
- Config lo=9/hi=5 free-run, `start` → `C` pulses 60 cycles apart at Q_lo=9/Q_hi=5, followed by wrap to 0/0.
- Config lo=2/hi=1 one-shot, `start` → `done`=1 after 6 counting cycles, counts held at 2/1, `cfg_ready`=1. `start` again → restart from 0/0.
- `stop` at Q_lo=5 in RUN:
  - without the macro → IDLE with 0/0;
  - with the macro → HOLD at 5, and `start` continues from 6.
- `cfg_valid` held during RUN → `cfg_ready`=0 and no capture. After `stop`, the transfer completes the next cycle.
- `MR` pulse mid-run at 7/3 → immediate 0/0, IDLE, term values back to 13/0, `C`=0.

Source files
------------

// File: rtl/zjh_cnt_pkg.sv
// zjh_cnt_pkg: shared state encoding and reset terminal counts for the cascaded counter controller
package zjh_cnt_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;
  localparam logic [3:0] TERM_LO_RST = 4'd13;
  localparam logic [3:0] TERM_HI_RST = 4'd0;
endpackage

// File: rtl/zjh_cnt4_stage.sv
// zjh_cnt4_stage: 4-bit synchronous counter stage with programmable terminal, carry in/out and async clear
module zjh_cnt4_stage (
  input  logic       Clk,
  input  logic       MR,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       ci_i,
  input  logic [3:0] term_i,
  output logic [3:0] q_o,
  output logic       tc_o,
  output logic       co_o
);
  logic [3:0] q_q, q_d;
  assign tc_o = q_q == term_i;
  assign co_o = ci_i & tc_o;
  assign q_o  = q_q;
  // clear dominates; an advancing stage at its terminal wraps to zero
  always_comb q_d = clr_i ? 4'd0 : (en_i & ci_i) ? (tc_o ? 4'd0 : q_q + 4'd1) : q_q;
  // count register, cleared asynchronously by MR
  always_ff @(posedge Clk or posedge MR)
    if (MR) q_q <= '0;
    else q_q <= q_d;
endmodule

// File: rtl/zjh_cnt_ctrl.sv
// zjh_cnt_ctrl: run controller for a units/tens cascaded counter; ZJH_CNT_CTRL_PAUSE_EN adds a HOLD (pause) state
module zjh_cnt_ctrl
  import zjh_cnt_pkg::*;
(
  input  logic       Clk,
  input  logic       MR,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_term_lo,
  input  logic [3:0] cfg_term_hi,
  input  logic       cfg_oneshot,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] Q_lo,
  output logic [3:0] Q_hi,
  output logic       C,
  output logic       busy,
  output logic       done
);
`ifdef ZJH_CNT_CTRL_PAUSE_EN
  localparam state_t STOP_TGT = HOLD;
`else
  localparam state_t STOP_TGT = IDLE;
`endif
  state_t     state_q, state_d;
  logic [3:0] term_lo_q, term_hi_q;
  logic       oneshot_q, busy_q, done_q, rdy_q;
  logic       tc_lo, tc_hi, co_lo, co_hi, term, en, clr;
  assign term = tc_lo & tc_hi;
  assign en   = (state_q == RUN) & (state_d == RUN);
  assign clr  = (state_d == IDLE) | ((state_d == RUN) & (state_q != RUN) & (state_q != HOLD));
  assign C         = co_hi & (state_q == RUN);
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_ready = rdy_q;
  zjh_cnt4_stage u_lo (
    .Clk(Clk), .MR(MR), .clr_i(clr), .en_i(en), .ci_i(1'b1), .term_i(term_lo_q),
    .q_o(Q_lo), .tc_o(tc_lo), .co_o(co_lo)
  );
  zjh_cnt4_stage u_hi (
    .Clk(Clk), .MR(MR), .clr_i(clr), .en_i(en), .ci_i(co_lo), .term_i(term_hi_q),
    .q_o(Q_hi), .tc_o(tc_hi), .co_o(co_hi)
  );
  // next state: stop beats start everywhere; a one-shot terminal parks in DONE
  always_comb
    state_d = (state_q == RUN) ? (stop ? STOP_TGT : (term & oneshot_q) ? DONE : RUN)
                               : (stop ? IDLE : start ? RUN : state_q);
  // state register with registered status outputs
  always_ff @(posedge Clk or posedge MR)
    if (MR) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d == RUN;
      done_q  <= state_d == DONE;
      rdy_q   <= (state_d == IDLE) | (state_d == DONE);
    end
  // configuration capture on a valid/ready transfer
  always_ff @(posedge Clk or posedge MR)
    if (MR) begin
      term_lo_q <= TERM_LO_RST;
      term_hi_q <= TERM_HI_RST;
      oneshot_q <= 1'b0;
    end else if (cfg_valid & rdy_q) begin
      term_lo_q <= cfg_term_lo;
      term_hi_q <= cfg_term_hi;
      oneshot_q <= cfg_oneshot;
    end
endmodule
